vga_timing: RTL
===============

# vga_timing

Generates 640x480@60 Hz VGA timing for the DE2 ADV7123 DAC from `clock_50`. It derives a 25 MHz pixel enable, runs horizontal and vertical counters, and drives `vga_clk`, `vga_hs`, `vga_vs`, `vga_blank` and `vga_sync`. It also exports pixel coordinates and frame markers. It sits directly upstream of the pixel/colour stage in the top level, which uses `vga_blank`, `x` and `y` to produce `vga_r`/`vga_g`/`vga_b`.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- clock_50  in  1  system clock, 50 MHz
- reset_n  in  1  asynchronous, active-low reset
- vga_clk  out  1  25 MHz DAC clock
- vga_hs  out  1  horizontal sync, active low
- vga_vs  out  1  vertical sync, active low
- vga_blank  out  1  high = visible pixel (DAC BLANK_N semantics)
- vga_sync  out  1  constant 0
- x  out  10  current horizontal count, 0..H_TOTAL-1
- y  out  10  current vertical count, 0..V_TOTAL-1
- pix_en  out  1  high in the `clock_50` cycle before each pixel advance
- frame_start  out  1  one `clock_50` cycle pulse when (x,y) becomes (0,0)
- frame_cnt  out  8  frame index, wraps 255 -> 0

## Operation
- Derived totals:
  - H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP (800).
  - V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP (525).
- `pix_en` is a toggle register:
  - Reset value 0; inverts on every `clock_50` edge.
  - `vga_clk` is driven by `pix_en`.
- Pixel advance: occurs on each edge where `pix_en` = 1.
  - h_cnt increments; H_TOTAL-1 wraps to 0.
  - On the h_cnt wrap, v_cnt increments; V_TOTAL-1 wraps to 0.
- All outputs are registered and updated on the advance edge from the next-state counters. `x`, `y`, `vga_hs`, `vga_vs` and `vga_blank` always describe the same pixel, with zero relative skew.
- x = h_cnt and y = v_cnt, with no clamping during blanking.
- `vga_blank` = 1 iff x < H_ACTIVE and y < V_ACTIVE.
- `vga_hs` = 0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
- `vga_vs` = 0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
- `frame_start` = 1 for exactly one `clock_50` cycle: the cycle following the advance edge at which (x,y) becomes (0,0).
- `frame_cnt` increments (mod 256) on the same edge that raises `frame_start`.
- Reset values: these equal the decode of the last pixel, so the first advance starts frame 0 cleanly.
  - pix_en = 0, h_cnt = 799, v_cnt = 524, x = 799, y = 524.
  - vga_hs = 1, vga_vs = 1, vga_blank = 0, vga_sync = 0.
  - frame_start = 0, frame_cnt = 8'hFF.
- Reset asserted mid-frame: all registers return to their reset values immediately (asynchronously). No partial line or frame state survives.

## Timing
- Edge 1 after reset_n rises: pix_en 0 -> 1.
- Edge 2 after reset_n rises:
  - (x,y) = (0,0), vga_blank = 1, frame_start = 1, frame_cnt = 0.
- Edge 3 after reset_n rises: frame_start = 0.
- Pixel period: 2 `clock_50` cycles.
- Line period: 1600 cycles.
- Frame period: 840000 cycles.
- `vga_clk` rises one `clock_50` cycle after the pixel outputs change, so the DAC samples mid-pixel.
- Horizontal sync, relative to the x = 0 edge:
  - hs falls 1312 cycles after x = 0 (x = 656).
  - hs stays low for 192 cycles, rising at x = 752.
- `vga_vs` is low for 2 full lines (3200 cycles), starting at the advance into (0,490).
- Changes to `vga_hs`, `vga_vs` and `vga_blank` occur only on advance edges, never on other edges.

## Test plan
- Reset check:
  - Stimulus: hold reset_n = 0 for 5 cycles.
  - Required: all outputs at their reset values; vga_clk = 0.
- First frame after reset:
  - Stimulus: release reset.
  - Required: at edge 2, (x,y) = (0,0), frame_start = 1 for 1 cycle, frame_cnt = 0.
  - Required: next frame_start exactly 840000 cycles later, with frame_cnt = 1.
- Horizontal decode:
  - Stimulus: run one full line.
  - Required: vga_blank high for exactly 640 pixels (1280 cycles).
  - Required: vga_hs low exactly for x = 656..751.
  - Required: x wraps 799 -> 0 and y increments on the same edge.
- Vertical decode:
  - Stimulus: run one full frame.
  - Required: vga_vs low only for y = 490..491.
  - Required: vga_blank = 0 for all y >= 480.
  - Required: y wraps 524 -> 0.
- Frame counter wrap:
  - Stimulus: parameters overridden to a small raster, H 4/1/1/1 and V 2/1/1/1. Run 257 frames.
  - Required: frame_cnt goes 0..255 then 0.
  - Required: one frame_start per frame, every 2·7·5 = 70 cycles.
- Reset mid-operation:
  - Stimulus: assert reset_n low at (x,y) = (300,200) for 1 cycle.
  - Required: outputs return to reset values asynchronously.
  - Required: after release, the frame restarts at (0,0) on edge 2 with frame_cnt = 0.

Source files
------------

// File: rtl/vga_timing.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : vga_timing
// Description : 640x480@60 raster timing for the ADV7123 DAC, pixel rate clock_50/2.
// Revision    : 1.0
// ============================================================================
module vga_timing #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clock_50,
    input  logic       reset_n,
    output logic       vga_clk,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_blank,
    output logic       vga_sync,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       pix_en,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam int CNT_W   = 10;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic             pix_en_q;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             blank_q, blank_d;
    logic             fstart_q, fstart_d;
    logic [7:0]       fcnt_q, fcnt_d;
    logic             w_advance;

    assign w_advance = pix_en_q;

    // Next pixel position and its decode; only committed on an advance edge so
    // that counters and all video outputs always move together.
    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end
        blank_d  = (h_cnt_d < H_VIS) && (v_cnt_d < V_VIS);
        hs_d     = !((h_cnt_d >= HS_START) && (h_cnt_d < HS_END));
        vs_d     = !((v_cnt_d >= VS_START) && (v_cnt_d < VS_END));
        fstart_d = w_advance && (h_cnt_d == '0) && (v_cnt_d == '0);
        fcnt_d   = fstart_d ? fcnt_q + 8'd1 : fcnt_q;
    end

    // Reset state is the decode of the last raster pixel, so the first advance
    // lands on (0,0) and starts frame 0.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            pix_en_q <= 1'b0;
            h_cnt_q  <= H_LAST;
            v_cnt_q  <= V_LAST;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            blank_q  <= 1'b0;
            fstart_q <= 1'b0;
            fcnt_q   <= 8'hFF;
        end else begin
            pix_en_q <= ~pix_en_q;
            fstart_q <= fstart_d;
            fcnt_q   <= fcnt_d;
            if (w_advance) begin
                h_cnt_q <= h_cnt_d;
                v_cnt_q <= v_cnt_d;
                hs_q    <= hs_d;
                vs_q    <= vs_d;
                blank_q <= blank_d;
            end
        end
    end

    assign vga_clk     = pix_en_q;
    assign pix_en      = pix_en_q;
    assign vga_hs      = hs_q;
    assign vga_vs      = vs_q;
    assign vga_blank   = blank_q;
    assign vga_sync    = 1'b0;
    assign x           = h_cnt_q;
    assign y           = v_cnt_q;
    assign frame_start = fstart_q;
    assign frame_cnt   = fcnt_q;

endmodule
`default_nettype wire
